// File: rtl/dff_pkg.sv
// Shared helpers for the delay line: counter width function and the stage record macro.
// The macro lets each instance build its stage record at its own WIDTH.
`ifndef DFF_PKG_SV
`define DFF_PKG_SV

`define DFF_STAGE_T(W) struct packed { logic valid; logic [(W)-1:0] data; }

package dff_pkg;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`endif

// File: rtl/dff_pipe_delay_if.sv
// Delay-line bus: advance/flush controls, input item, output item and occupancy.
// The master drives the controls and din; the slave (the delay line) returns dout and occupancy.
interface dff_pipe_delay_if
    import dff_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic                       en;
    logic                       flush;
    logic                       din_valid;
    logic [WIDTH-1:0]           din;
    logic                       dout_valid;
    logic [WIDTH-1:0]           dout;
    logic [occ_w(DEPTH)-1:0]    occupancy;

    modport master (
        output en, flush, din_valid, din,
        input  dout_valid, dout, occupancy
    );

    modport slave (
        input  en, flush, din_valid, din,
        output dout_valid, dout, occupancy
    );
endinterface

// File: rtl/dff_pipe_delay_en_stage.sv
// One register stage: 1 cycle per enabled edge; holds when en=0, clr drops valid only.
// Priority rst > clr > en; data is never touched by clr.
module dff_en_stage #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= RESET_VAL;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/dff_pipe_delay.sv
// Stallable, flushable DEPTH-stage delay line: DEPTH enabled edges of latency, en=0 stalls every stage.
// Outputs come straight from the last stage register; occupancy is a registered running count.
module dff_pipe_delay
    import dff_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          rst,
    dff_pipe_delay_if.slave bus
);
    localparam int OW = occ_w(DEPTH);

    typedef `DFF_STAGE_T(WIDTH) stage_t;

    stage_t          w_q [DEPTH];
    logic            w_enter;
    logic            w_leave;
    logic [OW-1:0]   r_occ;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        stage_t w_in;
        if (g == 0) begin : g_head
            assign w_in = {bus.din_valid, bus.din};
        end else begin : g_body
            assign w_in = w_q[g-1];
        end

        dff_en_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .i_en    (bus.en),
            .i_clr   (bus.flush),
            .i_valid (w_in.valid),
            .i_data  (w_in.data),
            .o_valid (w_q[g].valid),
            .o_data  (w_q[g].data)
        );
    end

    // Enter and leave in the same edge cancel, so the count never needs a popcount tree.
    assign w_enter = bus.en & bus.din_valid;
    assign w_leave = bus.en & w_q[DEPTH-1].valid;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + OW'(w_enter) - OW'(w_leave);
        end
    end

    assign bus.dout_valid = w_q[DEPTH-1].valid;
    assign bus.dout       = w_q[DEPTH-1].data;
    assign bus.occupancy  = r_occ;
endmodule

// File: tb/tb_dff_pipe_delay.sv
// Directed and randomised checks of the delay line at DEPTH=4/WIDTH=8 and DEPTH=1/WIDTH=1/RESET_VAL=1.
module tb_dff_pipe_delay;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    dff_pipe_delay_if #(.WIDTH(8), .DEPTH(4)) bus_a ();
    dff_pipe_delay_if #(.WIDTH(1), .DEPTH(1)) bus_b ();

    dff_pipe_delay #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    dff_pipe_delay #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b1)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hand-computed expectations, indexed by edge number within each case.
    int        s_occ  [9] = '{1, 2, 3, 4, 4, 3, 2, 1, 0};
    int        s_dv   [9] = '{0, 0, 0, 1, 1, 1, 1, 1, 0};
    int        s_dout [9] = '{0, 0, 0, 1, 2, 3, 4, 5, 0};
    int        st_en  [9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
    int        st_v   [9] = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
    int        st_d   [9] = '{'hA1, 'hA2, 'hEE, 'hEE, 'hEE, 0, 0, 0, 0};
    int        st_occ [9] = '{1, 2, 2, 2, 2, 2, 2, 1, 0};
    int        st_dv  [9] = '{0, 0, 0, 0, 0, 0, 1, 1, 0};
    int        b_v    [7] = '{1, 0, 1, 0, 0, 0, 0};
    int        b_d    [7] = '{'h10, 'h11, 'h12, 'h13, 0, 0, 0};
    int        b_occ  [7] = '{1, 1, 2, 2, 1, 1, 0};
    int        b_dv   [7] = '{0, 0, 0, 1, 0, 1, 0};
    int        b_dout [7] = '{0, 0, 0, 'h10, 'h11, 'h12, 'h13};
    int        f_fl   [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    int        f_v    [10] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    int        f_d    [10] = '{'h21, 'h22, 'h23, 'h24, 'h99, 'h55, 0, 0, 0, 0};
    int        f_occ  [10] = '{1, 2, 3, 4, 0, 1, 1, 1, 1, 0};
    int        f_dv   [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    int        f_dout [10] = '{0, 0, 0, 'h21, 'h21, 'h22, 'h23, 'h24, 'h55, 0};

    logic       mv [4];
    logic [7:0] md [4];
    logic       mbv;
    logic       mbd;
    int         pop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv_a(input logic e, input logic f, input logic v, input logic [7:0] d);
        bus_a.en        = e;
        bus_a.flush     = f;
        bus_a.din_valid = v;
        bus_a.din       = d;
    endtask

    task automatic drv_b(input logic e, input logic f, input logic v, input logic d);
        bus_b.en        = e;
        bus_b.flush     = f;
        bus_b.din_valid = v;
        bus_b.din       = d;
    endtask

    initial begin
        // Reset dominates en/din_valid on both instances.
        rst = 1'b1;
        drv_a(1'b1, 1'b0, 1'b1, 8'hFF);
        drv_b(1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        check("rst_a_dout", 32'(bus_a.dout), 32'h00);
        check("rst_a_dv",   32'(bus_a.dout_valid), 0);
        check("rst_a_occ",  32'(bus_a.occupancy), 0);
        check("rst_b_dout", 32'(bus_b.dout), 1);
        check("rst_b_dv",   32'(bus_b.dout_valid), 0);
        check("rst_b_occ",  32'(bus_b.occupancy), 0);

        // DEPTH=1: one enabled edge of latency.
        rst = 1'b0;
        drv_a(1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        check("d1_dout", 32'(bus_b.dout), 0);
        check("d1_dv",   32'(bus_b.dout_valid), 1);
        check("d1_occ",  32'(bus_b.occupancy), 1);
        drv_b(1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        check("d1_bub_dv",  32'(bus_b.dout_valid), 0);
        check("d1_bub_occ", 32'(bus_b.occupancy), 0);
        drv_b(1'b0, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 9; k++) begin
            drv_a(1'b1, 1'b0, (k < 5), 8'(k + 1));
            tick();
            check("stream_occ", 32'(bus_a.occupancy), 32'(s_occ[k]));
            check("stream_dv",  32'(bus_a.dout_valid), 32'(s_dv[k]));
            if (s_dv[k] != 0) check("stream_dout", 32'(bus_a.dout), 32'(s_dout[k]));
        end

        for (int k = 0; k < 9; k++) begin
            drv_a(st_en[k][0], 1'b0, st_v[k][0], 8'(st_d[k]));
            tick();
            check("stall_occ", 32'(bus_a.occupancy), 32'(st_occ[k]));
            check("stall_dv",  32'(bus_a.dout_valid), 32'(st_dv[k]));
            if (k == 6) check("stall_dout_a1", 32'(bus_a.dout), 32'hA1);
            if (k == 7) check("stall_dout_a2", 32'(bus_a.dout), 32'hA2);
            if (k == 8) check("stall_no_ee",   32'(bus_a.dout), 32'h00);
        end

        for (int k = 0; k < 7; k++) begin
            drv_a(1'b1, 1'b0, b_v[k][0], 8'(b_d[k]));
            tick();
            check("bubble_occ",  32'(bus_a.occupancy), 32'(b_occ[k]));
            check("bubble_dv",   32'(bus_a.dout_valid), 32'(b_dv[k]));
            check("bubble_dout", 32'(bus_a.dout), 32'(b_dout[k]));
        end

        for (int k = 0; k < 10; k++) begin
            drv_a(1'b1, f_fl[k][0], f_v[k][0], 8'(f_d[k]));
            tick();
            check("flush_occ", 32'(bus_a.occupancy), 32'(f_occ[k]));
            check("flush_dv",  32'(bus_a.dout_valid), 32'(f_dv[k]));
            if (k < 9) check("flush_dout", 32'(bus_a.dout), 32'(f_dout[k]));
        end

        // Random phase: reference models for both instances, occupancy checked against popcount.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mv[i] = 1'b0;
            md[i] = 8'h00;
        end
        mbv = 1'b0;
        mbd = 1'b1;
        for (int n = 0; n < 300; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            drv_a(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            drv_b(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (rst) begin
                for (int i = 0; i < 4; i++) begin
                    mv[i] = 1'b0;
                    md[i] = 8'h00;
                end
            end else if (bus_a.flush) begin
                for (int i = 0; i < 4; i++) mv[i] = 1'b0;
            end else if (bus_a.en) begin
                for (int i = 3; i > 0; i--) begin
                    mv[i] = mv[i-1];
                    md[i] = md[i-1];
                end
                mv[0] = bus_a.din_valid;
                md[0] = bus_a.din;
            end
            if (rst) begin
                mbv = 1'b0;
                mbd = 1'b1;
            end else if (bus_b.flush) begin
                mbv = 1'b0;
            end else if (bus_b.en) begin
                mbv = bus_b.din_valid;
                mbd = bus_b.din;
            end
            tick();
            pop = 0;
            for (int i = 0; i < 4; i++) pop += int'(mv[i]);
            check("rnd_a_occ",  32'(bus_a.occupancy), 32'(pop));
            check("rnd_a_dv",   32'(bus_a.dout_valid), 32'(mv[3]));
            check("rnd_a_dout", 32'(bus_a.dout), 32'(md[3]));
            check("rnd_b_occ",  32'(bus_b.occupancy), 32'(mbv));
            check("rnd_b_dv",   32'(bus_b.dout_valid), 32'(mbv));
            check("rnd_b_dout", 32'(bus_b.dout), 32'(mbd));
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
